// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
// Also imported by the receiver so both halves agree on the framing.
package uart_tx_buffered_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrapping pointers and a separate occupancy count.
// Asynchronous read of the head entry; a byte written on one edge is poppable from the next.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop FSM.
// serial_out is registered from the next-state values so the start bit appears on the pop edge.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             serial_q, serial_n;
  logic             symbol_end;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [7:0]       fifo_rd_data;

  assign data_in_ready = !fifo_full;
  assign serial_out    = serial_q;
  assign tx_busy       = (state != IDLE) || (fifo_count != '0);

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (data_in_valid && data_in_ready),
    .wr_data (data_in),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      serial_q <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      serial_q <= serial_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + CNT_W'(1);
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    fifo_pop   = 1'b0;
    symbol_end = (baud_cnt == CNT_LAST);

    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_rd_data;
          state_n  = START;
        end
      end
      START: begin
        if (symbol_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
        end
      end
      DATA: begin
        if (symbol_end) begin
          baud_cnt_n = '0;
          shift_n    = shift >> 1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (symbol_end) begin
          baud_cnt_n = '0;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_n  = fifo_rd_data;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   serial_n = 1'b0;
      DATA:    serial_n = shift_n[0];
      default: serial_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: timeline model of accepted bytes plus a line-decoding monitor.
module tb_uart_tx_buffered;

  localparam int unsigned CF    = 1000;
  localparam int unsigned BR    = 100;
  localparam int unsigned DEPTH = 4;
  localparam int          T     = CF / BR;
  localparam int          FRAME = 10 * T;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLOCK_FREQ (CF),
    .BAUD_RATE  (BR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .serial_out    (serial_out),
    .tx_busy       (tx_busy),
    .fifo_count    (fifo_count)
  );

  typedef struct {
    int         acc;
    int         start;
    logic [7:0] b;
  } frame_t;

  frame_t     frames[$];
  logic [7:0] acc_log[$];
  logic [7:0] mon_bytes[$];
  int         mon_err = 0;

  int   edge_k = 0;
  int   last_end = 0;
  logic m_ready = 1'b0;
  logic exp_serial, exp_busy, exp_ready;
  int   exp_count;

  int n_checks = 0;
  int n_errors = 0;

  // Line monitor: finds a start bit, samples each bit mid-period, verifies stop.
  int         mon_cnt = 0;
  bit         mon_active = 0;
  logic [7:0] mon_sh = '0;
  logic       mon_rst;

  always @(posedge clk) begin
    mon_rst = rst;
    #1;
    if (mon_rst) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (serial_out === 1'b0) begin
        mon_active = 1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == T / 2) begin
        if (serial_out !== 1'b0) begin
          mon_active = 0;
          mon_err++;
        end
      end else if (mon_cnt > T && mon_cnt < 9 * T && (mon_cnt % T) == T / 2) begin
        mon_sh[(mon_cnt - T) / T] = serial_out;
      end else if (mon_cnt == 9 * T + T / 2) begin
        if (serial_out !== 1'b1) mon_err++;
        else mon_bytes.push_back(mon_sh);
        mon_active = 0;
      end
    end
  end

  // One clock: drive inputs, advance the timeline model, then compute expectations after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    int   s;
    int   off;
    logic line_busy;
    frame_t f;
    rst = r;
    data_in_valid = v;
    data_in = d;
    @(posedge clk);
    edge_k++;
    if (r) begin
      frames.delete();
      last_end = 0;
    end else if (v && m_ready) begin
      s = (edge_k + 1 > last_end) ? edge_k + 1 : last_end;
      f.acc = edge_k;
      f.start = s;
      f.b = d;
      frames.push_back(f);
      acc_log.push_back(d);
      last_end = s + FRAME;
    end
    #1;
    while (frames.size() > 0 && frames[0].start + FRAME <= edge_k) void'(frames.pop_front());
    exp_serial = 1'b1;
    exp_count = 0;
    line_busy = 1'b0;
    foreach (frames[i]) begin
      if (frames[i].start > edge_k) begin
        exp_count++;
      end else begin
        line_busy = 1'b1;
        off = edge_k - frames[i].start;
        if (off < T) exp_serial = 1'b0;
        else if (off < 9 * T) exp_serial = frames[i].b[(off - T) / T];
      end
    end
    exp_busy = line_busy || (exp_count != 0);
    exp_ready = (exp_count < int'(DEPTH));
    m_ready = exp_ready;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && tx_busy !== 1'b0; i++) step(1'b0, 8'($urandom), 1'b0);
    repeat (3) step(1'b0, 8'($urandom), 1'b0);
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_timeout: tx_busy=%b required 0", tx_busy);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 51; i++) begin
      n_checks += 4;
      if (serial_out !== 1'b1) begin n_errors++; $display("FAIL reset_serial cyc %0d: got %b required 1", i, serial_out); end
      if (data_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready cyc %0d: got %b required 1", i, data_in_ready); end
      if (tx_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy cyc %0d: got %b required 0", i, tx_busy); end
      if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL reset_count cyc %0d: got %0d required 0", i, fifo_count); end
      step(1'b0, 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_single();
    int n;
    drain();
    mon_bytes.delete();
    step(1'b1, 8'hA5, 1'b0);
    n = edge_k;
    for (int i = 0; i < 105; i++) begin
      step(1'b0, 8'($urandom), 1'b0);
      n_checks += 2;
      if (serial_out !== exp_serial) begin n_errors++; $display("FAIL single_serial edge %0d: got %b required %b", edge_k - n, serial_out, exp_serial); end
      if (tx_busy !== exp_busy) begin n_errors++; $display("FAIL single_busy edge %0d: got %b required %b", edge_k - n, tx_busy, exp_busy); end
      if (edge_k == n + 1) begin
        n_checks++;
        if (serial_out !== 1'b0) begin n_errors++; $display("FAIL single_start_latency: got %b required 0", serial_out); end
      end
      if (edge_k == n + 100) begin
        n_checks++;
        if (tx_busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_end: got %b required 1", tx_busy); end
      end
      if (edge_k == n + 101) begin
        n_checks++;
        if (tx_busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_fall: got %b required 0", tx_busy); end
      end
    end
    n_checks++;
    if (mon_bytes.size() != 1 || mon_bytes[0] !== 8'hA5) begin
      n_errors++;
      $display("FAIL single_decode: got %0d bytes (first %h) required 1 byte a5", mon_bytes.size(), mon_bytes.size() > 0 ? mon_bytes[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [3];
    want[0] = 8'h00; want[1] = 8'hFF; want[2] = 8'h3C;
    drain();
    mon_bytes.delete();
    mon_err = 0;
    for (int i = 0; i < 3; i++) step(1'b1, want[i], 1'b0);
    for (int i = 0; i < 310; i++) begin
      step(1'b0, 8'($urandom), 1'b0);
      n_checks += 2;
      if (serial_out !== exp_serial) begin n_errors++; $display("FAIL b2b_serial edge %0d: got %b required %b", edge_k, serial_out, exp_serial); end
      if (fifo_count !== 3'(exp_count)) begin n_errors++; $display("FAIL b2b_count edge %0d: got %0d required %0d", edge_k, fifo_count, exp_count); end
    end
    n_checks += 2;
    if (mon_err != 0) begin n_errors++; $display("FAIL b2b_framing: got %0d framing errors required 0", mon_err); end
    if (mon_bytes.size() != 3) begin
      n_errors++;
      $display("FAIL b2b_decode_count: got %0d required 3", mon_bytes.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (mon_bytes[i] !== want[i]) begin n_errors++; $display("FAIL b2b_decode[%0d]: got %h required %h", i, mon_bytes[i], want[i]); end
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] sent [6];
    drain();
    mon_bytes.delete();
    for (int i = 0; i < 6; i++) begin
      sent[i] = 8'($urandom);
      step(1'b1, sent[i], 1'b0);
      n_checks += 2;
      if (data_in_ready !== exp_ready) begin n_errors++; $display("FAIL full_ready cyc %0d: got %b required %b", i, data_in_ready, exp_ready); end
      if (fifo_count !== 3'(exp_count)) begin n_errors++; $display("FAIL full_count cyc %0d: got %0d required %0d", i, fifo_count, exp_count); end
      if (fifo_count == 3'd4) begin
        n_checks++;
        if (data_in_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready_at_4: got %b required 0", data_in_ready); end
      end
    end
    drain();
    n_checks++;
    if (mon_bytes.size() != 5) begin
      n_errors++;
      $display("FAIL full_frames: got %0d required 5", mon_bytes.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (mon_bytes[i] !== sent[i]) begin n_errors++; $display("FAIL full_decode[%0d]: got %h required %h", i, mon_bytes[i], sent[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    drain();
    mon_bytes.delete();
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'($urandom), 1'b0);
    repeat (40) step(1'b0, 8'($urandom), 1'b0);
    step(1'b0, 8'($urandom), 1'b1);
    n_checks += 3;
    if (serial_out !== 1'b1) begin n_errors++; $display("FAIL midrst_serial: got %b required 1", serial_out); end
    if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL midrst_count: got %0d required 0", fifo_count); end
    if (tx_busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b required 0", tx_busy); end
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 8'($urandom), 1'b0);
      n_checks++;
      if (serial_out !== 1'b1) begin n_errors++; $display("FAIL midrst_quiet cyc %0d: got %b required 1", i, serial_out); end
    end
    n_checks++;
    if (mon_bytes.size() != 0) begin n_errors++; $display("FAIL midrst_frames: got %0d required 0", mon_bytes.size()); end
  endtask

  task automatic test_push_pop();
    logic [7:0] want [4];
    int n;
    drain();
    mon_bytes.delete();
    for (int i = 0; i < 4; i++) want[i] = 8'($urandom);
    step(1'b1, want[0], 1'b0);
    n = edge_k;
    step(1'b1, want[1], 1'b0);
    step(1'b1, want[2], 1'b0);
    while (edge_k < n + FRAME) step(1'b0, 8'($urandom), 1'b0);
    n_checks++;
    if (fifo_count !== 3'd2) begin n_errors++; $display("FAIL pushpop_pre: got %0d required 2", fifo_count); end
    step(1'b1, want[3], 1'b0);
    n_checks += 2;
    if (fifo_count !== 3'd2) begin n_errors++; $display("FAIL pushpop_count: got %0d required 2", fifo_count); end
    if (serial_out !== 1'b0) begin n_errors++; $display("FAIL pushpop_start: got %b required 0", serial_out); end
    drain();
    n_checks++;
    if (mon_bytes.size() != 4) begin
      n_errors++;
      $display("FAIL pushpop_frames: got %0d required 4", mon_bytes.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (mon_bytes[i] !== want[i]) begin n_errors++; $display("FAIL pushpop_order[%0d]: got %h required %h", i, mon_bytes[i], want[i]); end
      end
    end
  endtask

  task automatic test_random();
    logic v;
    drain();
    mon_bytes.delete();
    acc_log.delete();
    for (int i = 0; i < 3000; i++) begin
      v = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 29) == 0);
      step(v, 8'($urandom), 1'b0);
      n_checks += 4;
      if (serial_out !== exp_serial) begin n_errors++; $display("FAIL rand_serial edge %0d: got %b required %b", edge_k, serial_out, exp_serial); end
      if (fifo_count !== 3'(exp_count)) begin n_errors++; $display("FAIL rand_count edge %0d: got %0d required %0d", edge_k, fifo_count, exp_count); end
      if (data_in_ready !== exp_ready) begin n_errors++; $display("FAIL rand_ready edge %0d: got %b required %b", edge_k, data_in_ready, exp_ready); end
      if (tx_busy !== exp_busy) begin n_errors++; $display("FAIL rand_busy edge %0d: got %b required %b", edge_k, tx_busy, exp_busy); end
    end
    drain();
    n_checks++;
    if (mon_bytes.size() != acc_log.size()) begin
      n_errors++;
      $display("FAIL rand_frames: got %0d required %0d", mon_bytes.size(), acc_log.size());
    end else begin
      foreach (acc_log[i]) begin
        n_checks++;
        if (mon_bytes[i] !== acc_log[i]) begin n_errors++; $display("FAIL rand_decode[%0d]: got %h required %h", i, mon_bytes[i], acc_log[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid_frame();
    test_push_pop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
